// File: rtl/ca90_im_pkg.sv
// Shared types and constants for the sequential CA90 item memory.
//   ca90_im_state_e : controller states (idle, load bank base, step, result held)
//   Ca90ImPerm      : CA90 shift applied once per step cycle
//   sel_width()     : clog2 helper for index widths
//   bank_width()    : clog2 clamped to at least one bit, so a single-bank build still
//                     has a legal bank register
package ca90_im_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StStep = 2'd2,
    StDone = 2'd3
  } ca90_im_state_e;

  localparam int unsigned Ca90ImPerm = 7;

  function automatic int unsigned sel_width(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned bank_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ca90_hier_base.sv
// Expands one bank seed into a full-width base HV. Block 0 (LSBs) is the seed itself;
// each following SeedWidth-bit block is the previous block after one CA90 step
// (shift 1), so a small seed fills the whole hypervector.
// Ports:
//   seed_i : bank seed
//   hv_o   : base HV of the bank
module ca90_hier_base #(
  parameter int unsigned HVDimension = 512,
  parameter int unsigned SeedWidth   = 32
) (
  input  logic [SeedWidth-1:0]   seed_i,
  output logic [HVDimension-1:0] hv_o
);

  localparam int unsigned NumBlocks = HVDimension / SeedWidth;

  logic [SeedWidth-1:0] blocks [NumBlocks];

  assign blocks[0] = seed_i;

  for (genvar g = 1; g < NumBlocks; g++) begin : gen_chain
    ca90_unit #(
      .Width(SeedWidth),
      .Shift(1)
    ) u_blk (
      .hv_i(blocks[g-1]),
      .hv_o(blocks[g])
    );
  end

  for (genvar g = 0; g < NumBlocks; g++) begin : gen_pack
    assign hv_o[g*SeedWidth +: SeedWidth] = blocks[g];
  end

endmodule

// File: rtl/ca90_unit.sv
// One CA90 step over a Width-bit ring: each output bit is the XOR of the bits Shift
// places to its left and right, which is rotl(x, Shift) ^ rotr(x, Shift).
// Ports:
//   hv_i : current vector
//   hv_o : vector after one step
module ca90_unit #(
  parameter int unsigned Width = 512,
  parameter int unsigned Shift = 7
) (
  input  logic [Width-1:0] hv_i,
  output logic [Width-1:0] hv_o
);

  assign hv_o = {hv_i[Width-Shift-1:0], hv_i[Width-1:Width-Shift]} ^
                {hv_i[Shift-1:0], hv_i[Width-1:Shift]};

endmodule

// File: rtl/ca90_item_memory_seq.sv
// Sequential CA90 item memory. A request loads the hierarchical base of the item's
// bank and then applies one CA90 step per cycle until the wanted index is reached;
// the result is held on im_o with im_valid_o until consumed.
// Optional feature macro: CA90_IM_REUSE_EN. When defined, the last generated item is
// kept and a later request in the same bank at an equal or higher index continues from
// it instead of reloading; clr_i drops that cached state. When undefined, every request
// reloads and clr_i is ignored.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   seed_hv_i     : per-bank seeds, bank b at [b*SeedWidth +: SeedWidth]; held stable
//                   from acceptance through the load cycle
//   clr_i         : invalidate reuse cache
//   req_valid_i / req_ready_o / im_sel_i : request handshake and item index
//   im_valid_o / im_ready_i / im_o       : result handshake and item HV (registered)
//   busy_o        : controller not idle
module ca90_item_memory_seq
  import ca90_im_pkg::*;
#(
  parameter int unsigned HVDimension  = 512,
  parameter int unsigned NumTotIm     = 1024,
  parameter int unsigned NumPerImBank = 128,
  parameter int unsigned SeedWidth    = 32,
  parameter int unsigned Ca90ImPerm   = ca90_im_pkg::Ca90ImPerm,
  localparam int unsigned NumImSets   = NumTotIm / NumPerImBank,
  localparam int unsigned ImSelWidth  = sel_width(NumTotIm),
  localparam int unsigned IdxWidth    = sel_width(NumPerImBank),
  localparam int unsigned BankWidth   = bank_width(NumImSets)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumImSets*SeedWidth-1:0] seed_hv_i,
  input  logic                           clr_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [ImSelWidth-1:0]          im_sel_i,
  output logic                           im_valid_o,
  input  logic                           im_ready_i,
  output logic [HVDimension-1:0]         im_o,
  output logic                           busy_o
);

  ca90_im_state_e state_q, state_d;

  logic [HVDimension-1:0] cur_hv_q, cur_hv_d;
  logic [IdxWidth-1:0]    cur_idx_q, cur_idx_d;
  logic [IdxWidth-1:0]    tgt_idx_q, tgt_idx_d;
  logic [BankWidth-1:0]   bank_q, bank_d;  // bank captured at acceptance, drives the load

  logic [IdxWidth-1:0]    req_idx;
  logic [BankWidth-1:0]   req_bank;
  logic                   req_hit;
  logic [IdxWidth-1:0]    cur_idx_inc;

  logic [SeedWidth-1:0]   seed_arr [NumImSets];
  logic [SeedWidth-1:0]   seed_sel;
  logic [HVDimension-1:0] base_hv;
  logic [HVDimension-1:0] step_hv;

  assign req_idx     = im_sel_i[IdxWidth-1:0];
  assign req_bank    = BankWidth'(im_sel_i >> IdxWidth);
  assign cur_idx_inc = cur_idx_q + IdxWidth'(1);

  for (genvar g = 0; g < NumImSets; g++) begin : gen_seed
    assign seed_arr[g] = seed_hv_i[g*SeedWidth +: SeedWidth];
  end

  assign seed_sel = seed_arr[bank_q];

  ca90_hier_base #(
    .HVDimension(HVDimension),
    .SeedWidth  (SeedWidth)
  ) u_hier_base (
    .seed_i(seed_sel),
    .hv_o  (base_hv)
  );

  ca90_unit #(
    .Width(HVDimension),
    .Shift(Ca90ImPerm)
  ) u_step (
    .hv_i(cur_hv_q),
    .hv_o(step_hv)
  );

`ifdef CA90_IM_REUSE_EN
  logic                 cur_vld_q, cur_vld_d;
  logic [BankWidth-1:0] cur_bank_q, cur_bank_d;

  // Only forward stepping is possible, so a lower index in the same bank must reload.
  assign req_hit = cur_vld_q && (req_bank == cur_bank_q) && (req_idx >= cur_idx_q);

  always_comb begin
    cur_vld_d  = cur_vld_q;
    cur_bank_d = cur_bank_q;
    if (state_q == StLoad) begin
      cur_vld_d  = 1'b1;
      cur_bank_d = bank_q;
    end
    // A seed change wins over a concurrent load; the in-flight item still completes.
    if (clr_i) begin
      cur_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_vld_q  <= 1'b0;
      cur_bank_q <= '0;
    end else begin
      cur_vld_q  <= cur_vld_d;
      cur_bank_q <= cur_bank_d;
    end
  end
`else
  logic unused_clr;

  assign req_hit    = 1'b0;
  assign unused_clr = clr_i;
`endif

  always_comb begin
    state_d     = state_q;
    cur_hv_d    = cur_hv_q;
    cur_idx_d   = cur_idx_q;
    tgt_idx_d   = tgt_idx_q;
    bank_d      = bank_q;
    req_ready_o = 1'b0;
    im_valid_o  = 1'b0;
    busy_o      = 1'b1;
    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i) begin
          tgt_idx_d = req_idx;
          bank_d    = req_bank;
          if (req_hit) begin
            state_d = (req_idx > cur_idx_q) ? StStep : StDone;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        cur_hv_d  = base_hv;
        cur_idx_d = '0;
        state_d   = (tgt_idx_q != '0) ? StStep : StDone;
      end
      StStep: begin
        cur_hv_d  = step_hv;
        cur_idx_d = cur_idx_inc;
        if (cur_idx_inc == tgt_idx_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        im_valid_o = 1'b1;
        if (im_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cur_hv_q  <= '0;
      cur_idx_q <= '0;
      tgt_idx_q <= '0;
      bank_q    <= '0;
    end else begin
      state_q   <= state_d;
      cur_hv_q  <= cur_hv_d;
      cur_idx_q <= cur_idx_d;
      tgt_idx_q <= tgt_idx_d;
      bank_q    <= bank_d;
    end
  end

  // cur_hv only changes in load/step, so it is already stable while the result is held.
  assign im_o = cur_hv_q;

endmodule

// File: tb/tb_ca90_item_memory_seq.sv
module tb_ca90_item_memory_seq;

`ifdef CA90_IM_REUSE_EN
  localparam bit Reuse = 1'b1;
`else
  localparam bit Reuse = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] seed_hv;
  logic         clr;
  logic         req_valid;
  logic         req_ready;
  logic [9:0]   im_sel;
  logic         im_valid;
  logic         im_ready;
  logic [511:0] im;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] seeds [8];

  always #5 clk = ~clk;

  ca90_item_memory_seq #(
    .HVDimension (512),
    .NumTotIm    (1024),
    .NumPerImBank(128),
    .SeedWidth   (32),
    .Ca90ImPerm  (7)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .seed_hv_i  (seed_hv),
    .clr_i      (clr),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .im_sel_i   (im_sel),
    .im_valid_o (im_valid),
    .im_ready_i (im_ready),
    .im_o       (im),
    .busy_o     (busy)
  );

  // Reference model, written bit by bit with modular indexing.
  function automatic logic [31:0] m_blk_step(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[(i + 31) % 32] ^ x[(i + 1) % 32];
    return r;
  endfunction

  function automatic logic [511:0] m_item_step(input logic [511:0] x);
    logic [511:0] r;
    for (int i = 0; i < 512; i++) r[i] = x[(i + 512 - 7) % 512] ^ x[(i + 7) % 512];
    return r;
  endfunction

  function automatic logic [511:0] golden(input int b, input int k);
    logic [511:0] hv;
    logic [31:0]  blk;
    blk = seeds[b];
    for (int j = 0; j < 16; j++) begin
      hv[j*32 +: 32] = blk;
      blk = m_blk_step(blk);
    end
    for (int s = 0; s < k; s++) hv = m_item_step(hv);
    return hv;
  endfunction

  task automatic chk_int(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_hv(input string nm, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Issue one request, count cycles from the accept edge (inclusive) to im_valid,
  // capture the result, then complete the output handshake.
  task automatic do_req(input logic [9:0] sel, output int lat, output logic [511:0] hv);
    @(negedge clk);
    req_valid = 1'b1;
    im_sel    = sel;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!im_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    hv = im;
    @(negedge clk);
    im_ready = 1'b1;
    @(posedge clk);
    #1;
    im_ready = 1'b0;
  endtask

  typedef struct {
    logic [9:0] sel;
    int         lat;
    int         bank;
    int         idx;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int           lat;
    logic [511:0] hv;
    logic         stable;

    for (int i = 0; i < 8; i++) seeds[i] = 32'hA5C3_0F17 ^ (32'(i) * 32'h9E37_79B9);
    for (int i = 0; i < 8; i++) seed_hv[i*32 +: 32] = seeds[i];

    // sel, cycles from accept to valid, bank, idx
    vecs[0] = '{10'd0,    2,                0, 0};
    vecs[1] = '{10'd133,  7,                1, 5};
    vecs[2] = '{10'd140,  Reuse ? 8 : 14,   1, 12};
    vecs[3] = '{10'd140,  Reuse ? 1 : 14,   1, 12};
    vecs[4] = '{10'd130,  4,                1, 2};
    vecs[5] = '{10'd1023, 129,              7, 127};

    rst_n = 1'b0; clr = 1'b0; req_valid = 1'b0; im_sel = '0; im_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_int("reset req_ready", req_ready, 1);
    chk_int("reset im_valid", im_valid, 0);
    chk_hv("reset im_o", im, '0);
    chk_int("reset busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      do_req(vecs[v].sel, lat, hv);
      chk_int($sformatf("vec%0d latency", v), lat, vecs[v].lat);
      chk_hv($sformatf("vec%0d im_o", v), hv, golden(vecs[v].bank, vecs[v].idx));
      chk_int($sformatf("vec%0d idle after handshake", v), {req_ready, im_valid, busy}, 3'b100);
    end

    // Consumer stalls for 10 cycles: output and back-pressure must hold.
    @(negedge clk);
    req_valid = 1'b1;
    im_sel    = 10'd133;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!im_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    hv = im;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (im !== hv || req_ready !== 1'b0 || im_valid !== 1'b1) stable = 1'b0;
    end
    chk_int("stall latency", lat, 7);
    chk_hv("stall im_o", hv, golden(1, 5));
    chk_int("stall hold", stable, 1);
    @(negedge clk);
    im_ready = 1'b1;
    @(posedge clk);
    #1;
    im_ready = 1'b0;

    // clr pulse while stepping toward 131; the item still completes, but the following
    // same-bank forward request must reload.
    fork
      do_req(10'd131, lat, hv);
      begin
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
      end
    join
    chk_int("clr in-flight latency", lat, 5);
    chk_hv("clr in-flight im_o", hv, golden(1, 3));
    do_req(10'd136, lat, hv);
    chk_int("after clr latency", lat, 10);
    chk_hv("after clr im_o", hv, golden(1, 8));

    // Asynchronous reset in the middle of stepping.
    @(negedge clk);
    req_valid = 1'b1;
    im_sel    = 10'd1023;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_int("mid-step busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_int("mid reset req_ready", req_ready, 1);
    chk_int("mid reset im_valid", im_valid, 0);
    chk_hv("mid reset im_o", im, '0);
    chk_int("mid reset busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(10'd133, lat, hv);
    chk_int("post reset latency", lat, 7);
    chk_hv("post reset im_o", hv, golden(1, 5));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
